xnor_popcount_acc: RTL and testbench

- Upstream neighbour of the per-channel threshold-compare stage.
- Accumulates XNOR-popcount partial sums of binary activation beats against per-channel binary weight beats, across a programmable number of beats.
- Presents P_CHANNELS unsigned accumulators on oAccData, which drives the compare stage's iAccData bank directly.
- Flow control is a valid/ready beat handshake plus a hold-until-acknowledged result.

---
 rtl/xnor_acc_pkg.sv | 20 ++
 rtl/popcount_tree.sv | 32 +++
 rtl/xnor_popcount_acc.sv | 130 +++++++++++++
 tb/tb_xnor_popcount_acc.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xnor_acc_pkg.sv
// Shared types and default sizing for the XNOR-popcount accumulator slice.
// Defaults match the downstream threshold-compare stage.
package xnor_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  localparam int DEF_CHANNELS  = 64;
  localparam int DEF_BEATWIDTH = 64;
  localparam int DEF_ACCWIDTH  = 12;
  localparam int DEF_BEATCNTW  = 7;

  localparam int P_PCWIDTH = $clog2(DEF_BEATWIDTH + 1);
  localparam int ACC_MAX   = (1 << DEF_ACCWIDTH) - 1;

  // Width needed to hold a popcount of w bits (0..w inclusive)
  function automatic int pc_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Combinational popcount as a balanced binary adder tree.
// Leaves are padded to a power of two; node[1] is the root.
module popcount_tree #(
  parameter int W    = 64,
  parameter int OUTW = $clog2(W + 1)
) (
  input  logic [W-1:0]    bits,
  output logic [OUTW-1:0] count
);

  localparam int LEVELS = (W > 1) ? $clog2(W) : 0;
  localparam int L      = 1 << LEVELS;

  logic [OUTW-1:0] node [1:2*L-1];

  genvar i;
  for (i = 0; i < L; i++) begin : g_leaf
    if (i < W) begin : g_real
      assign node[L+i] = OUTW'(bits[i]);
    end else begin : g_pad
      assign node[L+i] = '0;
    end
  end

  // Heap-indexed internal nodes: children of node i are 2i and 2i+1
  for (i = 1; i < L; i++) begin : g_sum
    assign node[i] = node[2*i] + node[2*i+1];
  end

  assign count = node[1];

endmodule

// File: rtl/xnor_popcount_acc.sv
// Per-channel XNOR-popcount accumulator feeding the threshold-compare stage.
// Two-stage pipeline: popcount register, then saturating accumulate.
module xnor_popcount_acc
  import xnor_acc_pkg::*;
#(
  parameter int P_CHANNELS  = DEF_CHANNELS,
  parameter int P_BEATWIDTH = DEF_BEATWIDTH,
  parameter int P_ACCWIDTH  = DEF_ACCWIDTH,
  parameter int P_BEATCNTW  = DEF_BEATCNTW
) (
  input  logic                                   clk,
  input  logic                                   Rst,
  input  logic                                   iStart,
  input  logic [P_BEATCNTW-1:0]                  iBeats,
  input  logic                                   iValid,
  output logic                                   oReady,
  input  logic [P_BEATWIDTH-1:0]                 iAct,
  input  logic [P_CHANNELS-1:0][P_BEATWIDTH-1:0] iWeight,
  output logic [P_CHANNELS-1:0][P_ACCWIDTH-1:0]  oAccData,
  output logic                                   oAccValid,
  input  logic                                   iAccAck,
  output logic                                   oSat,
  output logic                                   oBusy
);

  localparam int PC_W  = pc_width(P_BEATWIDTH);
  localparam int SUM_W = P_ACCWIDTH + 1;

  state_t                           state;
  logic [P_BEATCNTW-1:0]            beats_target;
  logic [P_BEATCNTW-1:0]            beat_cnt;
  logic [P_CHANNELS-1:0][PC_W-1:0]  pc_comb;
  logic [P_CHANNELS-1:0][PC_W-1:0]  pc_q;
  logic                             s1_valid;
  logic [SUM_W-1:0]                 sum [P_CHANNELS];
  logic [P_CHANNELS-1:0]            ovf;
  logic                             accept;
  logic                             last_beat;

  assign accept    = iValid && oReady;
  assign last_beat = (beat_cnt == beats_target - 1'b1);

  // Sum carries one extra bit; a set carry means the channel must clamp
  genvar ch;
  for (ch = 0; ch < P_CHANNELS; ch++) begin : g_ch
    popcount_tree #(
      .W    (P_BEATWIDTH),
      .OUTW (PC_W)
    ) u_pc (
      .bits  (~(iAct ^ iWeight[ch])),
      .count (pc_comb[ch])
    );
    assign sum[ch] = {1'b0, oAccData[ch]} + SUM_W'(pc_q[ch]);
    assign ovf[ch] = sum[ch][P_ACCWIDTH];
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      s1_valid <= 1'b0;
      pc_q     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) pc_q <= pc_comb;
    end
  end

  // DRAIN exits only once stage 1 is empty, so the last add lands before DONE
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      beats_target <= '0;
      beat_cnt     <= '0;
      oAccData     <= '0;
      oReady       <= 1'b0;
      oAccValid    <= 1'b0;
      oSat         <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      if (s1_valid) begin
        for (int c = 0; c < P_CHANNELS; c++) begin
          oAccData[c] <= ovf[c] ? {P_ACCWIDTH{1'b1}} : sum[c][P_ACCWIDTH-1:0];
        end
        if (|ovf) oSat <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (iStart) begin
            beats_target <= iBeats;
            beat_cnt     <= '0;
            oAccData     <= '0;
            oSat         <= 1'b0;
            oBusy        <= 1'b1;
            if (iBeats != '0) begin
              state  <= ACCUM;
              oReady <= 1'b1;
            end else begin
              state     <= DONE;
              oAccValid <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state  <= DRAIN;
              oReady <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state     <= DONE;
            oAccValid <= 1'b1;
          end
        end
        DONE: begin
          if (iAccAck) begin
            state     <= IDLE;
            oAccValid <= 1'b0;
            oBusy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
// Scoreboard bench for xnor_popcount_acc: driver pushes expected results,
// a negedge monitor pops and compares whenever oAccValid rises.
module tb_xnor_popcount_acc;

  localparam int CH  = 64;
  localparam int BW  = 64;
  localparam int AW  = 12;
  localparam int BCW = 7;
  localparam int SATV = 4095;

  typedef logic [CH-1:0][AW-1:0] accvec_t;
  typedef logic [CH-1:0][BW-1:0] wvec_t;
  typedef struct {
    accvec_t acc;
    logic    sat;
    int      beats;
    int      start_acc;
    int      last_edge;
  } exp_t;

  logic           clk = 1'b0;
  logic           Rst;
  logic           iStart;
  logic [BCW-1:0] iBeats;
  logic           iValid;
  logic           oReady;
  logic [BW-1:0]  iAct;
  wvec_t          iWeight;
  accvec_t        oAccData;
  logic           oAccValid;
  logic           iAccAck;
  logic           oSat;
  logic           oBusy;

  xnor_popcount_acc dut (
    .clk       (clk),
    .Rst       (Rst),
    .iStart    (iStart),
    .iBeats    (iBeats),
    .iValid    (iValid),
    .oReady    (oReady),
    .iAct      (iAct),
    .iWeight   (iWeight),
    .oAccData  (oAccData),
    .oAccValid (oAccValid),
    .iAccAck   (iAccAck),
    .oSat      (oSat),
    .oBusy     (oBusy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accepted = 0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (iValid && oReady) accepted <= accepted + 1;
  end

  exp_t       sb[$];
  logic [BW-1:0] act_q[$];
  wvec_t      wt_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: per-beat XNOR popcount with clamp at 4095
  function automatic accvec_t model(input int n, output logic sat);
    accvec_t r;
    int a;
    sat = 1'b0;
    for (int c = 0; c < CH; c++) begin
      a = 0;
      for (int b = 0; b < n; b++) begin
        a = a + $countones(~(act_q[b] ^ wt_q[b][c]));
        if (a > SATV) begin
          a = SATV;
          sat = 1'b1;
        end
      end
      r[c] = AW'(a);
    end
    return r;
  endfunction

  task automatic addRandomBeat();
    wvec_t w;
    for (int c = 0; c < CH; c++) w[c] = {$urandom, $urandom};
    act_q.push_back({$urandom, $urandom});
    wt_q.push_back(w);
  endtask

  // Issues a job; stop_after>0 abandons it after that many acceptances
  task automatic applyStimulus(input int n, input int stop_after, input bit gap, input int start_at);
    exp_t e;
    int sent, last, guard, drops, base;
    bit tog, acc_now;
    base = accepted;
    @(posedge clk); #1;
    iStart = 1'b1;
    iBeats = BCW'(n);
    @(posedge clk); #1;
    iStart = 1'b0;
    sent = 0; last = -1; guard = 0; drops = 0; tog = 1'b0;
    while (sent < n && guard < 1000) begin
      guard++;
      iValid  = gap ? ~tog : 1'b1;
      tog     = ~tog;
      iAct    = act_q[sent];
      iWeight = wt_q[sent];
      if (start_at >= 0 && sent == start_at && iValid) begin
        iStart = 1'b1;
        iBeats = 7'd3;
      end
      @(negedge clk);
      acc_now = iValid && oReady;
      if (!oReady) drops++;
      @(posedge clk); #1;
      iStart = 1'b0;
      if (acc_now) begin
        sent++;
        last = cycle;
      end
      if (stop_after > 0 && sent == stop_after) break;
    end
    iValid = 1'b0;
    if (guard >= 1000) checkOutput("timeout_beats", sent, n);
    if (stop_after > 0) return;
    if (gap) checkOutput("ready_in_accum", drops, 0);
    e.acc       = model(n, e.sat);
    e.beats     = n;
    e.start_acc = base;
    e.last_edge = (n > 0) ? last : -1;
    sb.push_back(e);
    if (n > 0) begin
      @(negedge clk);
      checkOutput("ready_after_last", oReady, 0);
    end
  endtask

  task automatic waitValid();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!oAccValid && t < 400);
    if (!oAccValid) checkOutput("timeout_valid", oAccValid, 1);
  endtask

  task automatic ackResult();
    @(posedge clk); #1;
    iAccAck = 1'b1;
    @(posedge clk); #1;
    iAccAck = 1'b0;
    @(negedge clk);
    checkOutput("valid_after_ack", oAccValid, 0);
    checkOutput("busy_after_ack", oBusy, 0);
  endtask

  // Monitor: one scoreboard entry per rising oAccValid
  initial begin
    exp_t e;
    int nbad, first;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (oAccValid === 1'b1 && !prev_valid) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          nbad = 0;
          first = -1;
          for (int c = 0; c < CH; c++) begin
            if (oAccData[c] !== e.acc[c]) begin
              nbad++;
              if (first < 0) first = c;
            end
          end
          if (first >= 0)
            $display("[TB] first bad channel %0d got %0d want %0d", first, oAccData[first], e.acc[first]);
          checkOutput("acc_bad_channels", nbad, 0);
          checkOutput("sat_flag", oSat, e.sat);
          checkOutput("beats_accepted", accepted - e.start_acc, e.beats);
          if (e.last_edge >= 0) checkOutput("valid_latency", cycle - e.last_edge, 2);
        end
      end
      prev_valid = oAccValid;
    end
  end

  initial begin
    wvec_t w;
    accvec_t held;
    int diffs;
    Rst = 1'b1; iStart = 1'b0; iBeats = '0; iValid = 1'b0;
    iAct = '0; iWeight = '0; iAccAck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", oReady, 0);
    checkOutput("rst_valid", oAccValid, 0);
    checkOutput("rst_sat", oSat, 0);
    checkOutput("rst_busy", oBusy, 0);
    Rst = 1'b0;

    $display("[TB] reset mid-accumulation");
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 5; b++) addRandomBeat();
    applyStimulus(5, 3, 1'b0, -1);
    #2 Rst = 1'b1;
    #1;
    checkOutput("midrst_ready", oReady, 0);
    checkOutput("midrst_busy", oBusy, 0);
    checkOutput("midrst_acc_zero", (oAccData == '0), 1);
    @(negedge clk);
    Rst = 1'b0;
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 3; b++) addRandomBeat();
    applyStimulus(3, 0, 1'b0, -1);
    waitValid();
    ackResult();

    $display("[TB] basic two-beat job");
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < CH; c++) w[c] = {$urandom, $urandom};
      w[0] = {BW{1'b1}};
      w[1] = '0;
      w[2] = 64'h0000_0000_FFFF_FFFF;
      act_q.push_back({BW{1'b1}});
      wt_q.push_back(w);
    end
    applyStimulus(2, 0, 1'b0, -1);
    waitValid();
    checkOutput("basic_ch0", oAccData[0], 128);
    checkOutput("basic_ch1", oAccData[1], 0);
    checkOutput("basic_ch2", oAccData[2], 64);
    ackResult();

    $display("[TB] gapped valid, held result");
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 4; b++) addRandomBeat();
    applyStimulus(4, 0, 1'b1, -1);
    waitValid();
    held = oAccData;
    repeat (3) @(negedge clk);
    checkOutput("hold_valid", oAccValid, 1);
    diffs = 0;
    for (int c = 0; c < CH; c++) if (oAccData[c] !== held[c]) diffs++;
    checkOutput("hold_data_stable", diffs, 0);
    ackResult();

    $display("[TB] saturation");
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 70; b++) begin
      addRandomBeat();
      w = wt_q[b];
      w[5] = act_q[b];
      wt_q[b] = w;
    end
    applyStimulus(70, 0, 1'b0, -1);
    waitValid();
    checkOutput("sat_ch5", oAccData[5], SATV);
    checkOutput("sat_set", oSat, 1);
    ackResult();

    $display("[TB] zero-beat job clears sat");
    applyStimulus(0, 0, 1'b0, -1);
    @(negedge clk);
    checkOutput("zero_sat_cleared", oSat, 0);
    checkOutput("zero_valid", oAccValid, 1);
    ackResult();

    $display("[TB] start ignored during accumulation");
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 5; b++) addRandomBeat();
    applyStimulus(5, 0, 1'b0, 2);
    waitValid();
    ackResult();

    $display("[TB] start with ack in done");
    act_q.delete(); wt_q.delete();
    for (int b = 0; b < 2; b++) addRandomBeat();
    applyStimulus(2, 0, 1'b0, -1);
    waitValid();
    @(posedge clk); #1;
    iStart = 1'b1; iBeats = 7'd1; iAccAck = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0; iAccAck = 1'b0;
    @(negedge clk);
    checkOutput("simul_busy", oBusy, 0);
    checkOutput("simul_valid", oAccValid, 0);
    @(negedge clk);
    checkOutput("simul_no_restart", oBusy, 0);
    act_q.delete(); wt_q.delete();
    addRandomBeat();
    applyStimulus(1, 0, 1'b0, -1);
    waitValid();
    ackResult();

    repeat (2) @(negedge clk);
    checkOutput("sb_leftover", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
